// File: rtl/mult_sched.sv
// Round-robin front end for a shared 4x4 multiplier core.
// Grants one requester, runs the core handshake with a timeout, holds the result until acked.
module mult_sched #(
  parameter int TMO = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [3:0]  gnt,
  output logic        res_valid,
  output logic [1:0]  res_id,
  output logic [7:0]  res_p,
  output logic        res_err,
  input  logic        res_ack,
  output logic        start,
  output logic [3:0]  a,
  output logic [3:0]  b,
  input  logic        ready,
  input  logic [7:0]  p,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    DONE
  } state_t;

  localparam logic [4:0] TMO_W = 5'(TMO);

  state_t     state;
  logic [1:0] ptr;
  logic [4:0] cnt;
  logic [4:0] cnt_nx;
  logic [1:0] pick;
  logic       hit;
  logic       tmo_hit;

  // Scan from ptr upward; the descending loop lets the nearest hit win.
  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
        hit  = 1'b1;
      end
    end
  end

  assign gnt = (state == IDLE && hit && !rst)
             ? (4'b0001 << pick) : 4'b0000;

  assign cnt_nx  = cnt + 5'd1;
  assign tmo_hit = (cnt_nx == TMO_W);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 5'd0;
      start     <= 1'b0;
      a         <= 4'd0;
      b         <= 4'd0;
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      res_p     <= 8'd0;
      res_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            a      <= req_a[{pick, 2'b00} +: 4];
            b      <= req_b[{pick, 2'b00} +: 4];
            res_id <= pick;
            ptr    <= pick + 2'd1;
            cnt    <= 5'd0;
            start  <= 1'b1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT_LO;
        WAIT_LO, WAIT_HI: begin
          cnt <= cnt_nx;
          // Timeout wins over a READY edge landing in the same cycle.
          if (tmo_hit) begin
            res_p     <= 8'd0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            timeout   <= 1'b1;
            state     <= DONE;
          end else if (state == WAIT_LO) begin
            if (!ready) state <= WAIT_HI;
          end else if (ready) begin
            res_p     <= p;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
